prince_cfb_ctrl: RTL and testbench

PRINCE_CFB_CTRL -- requirements
Module: prince_cfb_ctrl

---
 rtl/prince_cfb_ctrl.sv | 135 +++++++++++++
 tb/tb_prince_cfb_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prince_cfb_ctrl.sv
// 16-bit CFB controller driving a PRINCE core over 64-bit words.
// Each word is split into four 16-bit segments handled in order 3,2,1,0.
// Every segment gets one core call; its keystream is XORed onto the segment.
// The feedback register chains across segments and across words.
`timescale 1ns/1ps

module prince_cfb_ctrl #(
  parameter logic CORE_ENC = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iv_load,
  input  logic [15:0] iv,
  input  logic        mode,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy,
  output logic        core_start,
  output logic [1:0]  core_outer_idx,
  output logic [15:0] core_text,
  output logic        core_encrypt,
  input  logic        core_done,
  input  logic [15:0] core_result
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_OUT
  } state_t;

  state_t      state;
  logic [15:0] fb;        // CFB feedback value, persists across words
  logic [1:0]  seg;       // segment currently being processed
  logic [63:0] din_q;     // latched input word
  logic        mode_q;    // latched direction, 1 = decrypt
  logic [63:0] dout_q;    // result word, filled one segment at a time
  logic        start_q;
  logic        valid_q;
  logic        busy_q;

  logic [15:0] seg_in;
  logic [15:0] seg_res;
  logic [15:0] fb_next;

  // Current input segment, its CFB result, and the value that feeds back.
  // Encrypt chains on the ciphertext it produced; decrypt chains on the
  // ciphertext it received, so both directions share one keystream.
  always_comb begin
    seg_in  = din_q[{seg, 4'b0000} +: 16];
    seg_res = seg_in ^ core_result;
    fb_next = mode_q ? seg_in : seg_res;
  end

  // NOTE: in_ready is decoded combinationally because it must drop in the
  // same cycle iv_load rises; a registered copy would lag by one cycle.
  assign in_ready       = (state == ST_IDLE) && !iv_load;
  assign out_valid      = valid_q;
  assign out_data       = dout_q;
  assign busy           = busy_q;
  assign core_start     = start_q;
  // seg and fb only change on core_done, so they are stable START..done.
  assign core_outer_idx = seg;
  assign core_text      = fb;
  assign core_encrypt   = CORE_ENC;

  // Control FSM with its registered outputs and the datapath registers.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      fb      <= '0;
      seg     <= 2'd3;
      din_q   <= '0;
      mode_q  <= 1'b0;
      dout_q  <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iv_load) begin
            fb <= iv;
          end else if (in_valid) begin
            din_q   <= in_data;
            mode_q  <= mode;
            seg     <= 2'd3;
            state   <= ST_START;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          start_q <= 1'b0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_done) begin
            dout_q[{seg, 4'b0000} +: 16] <= seg_res;
            fb <= fb_next;
            if (seg == 2'd0) begin
              state   <= ST_OUT;
              valid_q <= 1'b1;
            end else begin
              seg     <= seg - 2'd1;
              state   <= ST_START;
              start_q <= 1'b1;
            end
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            state   <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          start_q <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prince_cfb_ctrl.sv
// Bench for prince_cfb_ctrl with a stub core (result = text ^ A5A5, done
// three cycles after start). A word-level CFB model predicts every output
// on every cycle; directed tests add hand-computed literal expectations.
`timescale 1ns/1ps

module tb_prince_cfb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv_load = 1'b0;
  logic [15:0] iv = '0;
  logic        mode = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        busy;
  logic        core_start;
  logic [1:0]  core_outer_idx;
  logic [15:0] core_text;
  logic        core_encrypt;
  logic        core_done;
  logic [15:0] core_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prince_cfb_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .iv_load        (iv_load),
    .iv             (iv),
    .mode           (mode),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .busy           (busy),
    .core_start     (core_start),
    .core_outer_idx (core_outer_idx),
    .core_text      (core_text),
    .core_encrypt   (core_encrypt),
    .core_done      (core_done),
    .core_result    (core_result)
  );

  // Stub core: not reset, so a call in flight at reset returns a late done.
  logic [1:0]  stub_sr = '0;
  logic        stub_done = 1'b0;
  logic [15:0] stub_text = '0;
  logic        stray = 1'b0;

  always @(posedge clk) begin
    stub_sr   <= {stub_sr[0], core_start};
    stub_done <= stub_sr[1];
    if (core_start) stub_text <= core_text;
  end

  assign core_done   = stub_done | stray;
  assign core_result = stub_text ^ 16'hA5A5;

  // Log of segment indices seen at each core_start, newest in the low bits.
  logic [7:0] idx_log = '0;
  always @(negedge clk) begin
    if (core_start) idx_log <= {idx_log[5:0], core_outer_idx};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level model: whole-word CFB result, final feedback and the
  // feedback value presented to the core for each segment.
  typedef struct packed {
    logic [63:0]       res;
    logic [15:0]       fb;
    logic [3:0][15:0]  fbs;
  } word_t;

  function automatic word_t cfb_model(input logic [15:0] fb_in, input logic [63:0] d,
                                      input logic m);
    word_t       w;
    logic [15:0] f, x, r;
    f = fb_in;
    w.res = '0;
    w.fbs = '0;
    for (int i = 3; i >= 0; i--) begin
      w.fbs[i] = f;
      x = d[i*16 +: 16];
      r = x ^ (f ^ 16'hA5A5);
      w.res[i*16 +: 16] = r;
      f = m ? x : r;
    end
    w.fb = f;
    return w;
  endfunction

  // Model timing: a word occupies 16 cycles of core activity, then waits
  // for out_ready. m_cnt counts cycles since acceptance (1..16).
  logic        m_idle = 1'b1;
  logic        m_ov = 1'b0;
  int          m_cnt = 0;
  logic [15:0] m_fb = '0;
  logic [1:0]  m_idx = 2'd3;
  word_t       m_word = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_idle <= 1'b1;
      m_ov   <= 1'b0;
      m_cnt  <= 0;
      m_fb   <= '0;
      m_idx  <= 2'd3;
    end else if (m_ov) begin
      if (out_ready) begin
        m_ov   <= 1'b0;
        m_idle <= 1'b1;
      end
    end else if (!m_idle) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 16) begin
        m_ov  <= 1'b1;
        m_fb  <= m_word.fb;
        m_idx <= 2'd0;
      end
    end else if (iv_load) begin
      m_fb <= iv;
    end else if (in_valid) begin
      m_word <= cfb_model(m_fb, in_data, mode);
      m_idle <= 1'b0;
      m_cnt  <= 1;
    end
  end

  // Cycle-by-cycle comparison of the DUT against the model.
  int          e_seg;
  logic [1:0]  e_idx;
  logic [15:0] e_text;
  logic        e_start;

  always @(negedge clk) begin
    if (!m_idle && !m_ov) begin
      e_seg   = 3 - (m_cnt - 1) / 4;
      e_idx   = 2'(e_seg);
      e_text  = m_word.fbs[e_seg];
      e_start = ((m_cnt - 1) % 4) == 0;
    end else begin
      e_idx   = m_idx;
      e_text  = m_fb;
      e_start = 1'b0;
    end
    check("busy", busy, !m_idle);
    check("in_ready", in_ready, m_idle && !iv_load);
    check("out_valid", out_valid, m_ov);
    check("core_start", core_start, e_start);
    check("core_outer_idx", core_outer_idx, e_idx);
    check("core_text", core_text, e_text);
    if (m_ov) check("out_data", out_data, m_word.res);
    else if (!rst_n) check("out_data_rst", out_data, 64'h0);
  end

  task automatic load_iv(input logic [15:0] v);
    iv = v;
    iv_load = 1'b1;
    @(posedge clk);
    #1 iv_load = 1'b0;
  endtask

  task automatic send_word(input logic m, input logic [63:0] d);
    int n;
    mode = m;
    in_data = d;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("accept_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic recv_word(input int hold, output logic [63:0] d, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
    check("out_valid_timeout", out_valid, 1'b1);
    d = out_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1'b1);
      check("hold_data", out_data, d);
    end
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_core_start", core_start, 1'b0);
    check("rst_outer_idx", core_outer_idx, 2'd3);
    check("rst_core_text", core_text, 16'h0);
    check("rst_out_data", out_data, 64'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [63:0] r1, r2, c, p;
    int          lat, n, seen;
    logic [63:0] plain;

    // Reset state
    repeat (2) @(negedge clk);
    #1 check_reset_outputs();
    check("core_encrypt", core_encrypt, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    // Encrypt zero word from IV 0: latency, index order, literal result
    load_iv(16'h0000);
    send_word(1'b0, 64'h0);
    recv_word(0, r1, lat);
    check("enc0_latency", 64'(lat), 64'd17);
    check("enc0_data", r1, 64'hA5A5_0000_A5A5_0000);
    check("enc0_idx_order", idx_log, 8'b11_10_01_00);

    // Decrypt round trip from IV 0
    load_iv(16'h0000);
    send_word(1'b1, 64'hA5A5_0000_A5A5_0000);
    recv_word(0, r1, lat);
    check("dec0_data", r1, 64'h0);

    // Two chained encrypts, stray done in START, held output on the second
    send_word(1'b0, 64'h0);
    stray = 1'b1;
    @(posedge clk);
    #1 stray = 1'b0;
    recv_word(0, r1, lat);
    send_word(1'b0, 64'h0);
    recv_word(5, r2, lat);
    check("chain_first", r1, 64'hA5A5_0000_A5A5_0000);
    check("chain_second", r2, 64'hA5A5_0000_A5A5_0000);

    // iv_load and in_valid together: IV wins, word taken next cycle
    iv = 16'hBEEF;
    iv_load = 1'b1;
    in_data = 64'h0;
    mode = 1'b0;
    in_valid = 1'b1;
    #1 check("ivload_blocks_ready", in_ready, 1'b0);
    @(posedge clk);
    #1 iv_load = 1'b0;
    send_word(1'b0, 64'h0);
    recv_word(0, r1, lat);
    check("iv_beef_data", r1, 64'h1B4A_BEEF_1B4A_BEEF);

    // Round trip on a mixed pattern; iv_load and in_valid during a word ignored
    plain = 64'h0123_4567_89AB_CDEF;
    load_iv(16'h1234);
    send_word(1'b0, plain);
    iv = 16'hFFFF;
    iv_load = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    iv_load = 1'b0;
    in_valid = 1'b0;
    recv_word(2, c, lat);
    load_iv(16'h1234);
    send_word(1'b1, c);
    recv_word(0, p, lat);
    check("roundtrip_data", p, plain);

    // Reset while waiting on segment 1
    send_word(1'b0, 64'h1111_2222_3333_4444);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(core_start && core_outer_idx == 2'd1) && n < 100);
    check("seg1_start_timeout", core_outer_idx, 2'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    stray = 1'b1;
    @(posedge clk);
    #1 stray = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_valid_after_reset", 64'(seen), 64'd0);
    send_word(1'b0, 64'h0);
    recv_word(0, r1, lat);
    check("post_reset_data", r1, 64'hA5A5_0000_A5A5_0000);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
